// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: word RAM with 1-cycle read latency, RMW sub-word stores.
// Define MEM_SUBWORD_EN to enable byte/halfword accesses; otherwise only word accesses are legal.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MERGE = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic                  accept, req_err, word_store;
    logic [31:0]           load_data;

    assign accept     = req_valid & req_ready;
    assign word_store = req_we & (req_size == 2'b10);

`ifdef MEM_SUBWORD_EN
    logic [1:0]  lane_q, size_q;
    logic        uns_q;
    logic [15:0] wdata_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] merge_data;

    assign req_err = (req_size == 2'b11) | ((req_size == 2'b01) & req_addr[0]) |
                     ((req_size == 2'b10) & (|req_addr[1:0]));

    always_comb begin
        ld_byte = ram_dout[{lane_q, 3'b000} +: 8];
        ld_half = ram_dout[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   load_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: load_data = ram_dout;
        endcase
        merge_data = ram_dout;
        if (size_q == 2'b00)
            merge_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lane_q  <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[15:0];
        end
    end
`else
    logic unused_ok;
    assign unused_ok = req_unsigned;
    assign req_err   = (req_size != 2'b10) | (|req_addr[1:0]);
    assign load_data = ram_dout;
`endif

    always_ff @(posedge clk) begin
        if (accept)
            waddr_q <= req_addr[ADDR_WIDTH+1:2];
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = waddr_q;
        ram_din   = req_wdata;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                ram_addr  = req_addr[ADDR_WIDTH+1:2];
                if (accept && !req_err) begin
                    if (!req_we)
                        state_nxt = LOAD;
                    else if (word_store)
                        ram_we = 1'b1;
`ifdef MEM_SUBWORD_EN
                    else
                        state_nxt = MERGE;
`endif
                end
            end
            LOAD: state_nxt = IDLE;
`ifdef MEM_SUBWORD_EN
            MERGE: begin
                // ram_dout here is the read issued in the accept cycle
                ram_we    = ~rst;
                ram_din   = merge_data;
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
        if (rst)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            if (accept && (req_err || word_store)) begin
                rsp_valid <= 1'b1;
                rsp_err   <= req_err;
                rsp_rdata <= 32'd0;
            end else if (state != IDLE) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= (state == LOAD) ? load_data : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed vectors push expected responses, a monitor pops/compares.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err, ram_we;
    logic [31:0] rsp_rdata, ram_din, ram_dout;
    logic [7:0]  ram_addr;

    mem_access_unit #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM with registered read address
    logic [31:0] mem [256];
    logic [7:0]  raddr;
    always @(posedge clk) begin
        raddr <= ram_addr;
        if (ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[raddr];

    int cyc = 0;
    int we_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t q[$];

    int nvec = 0;
    int nerr = 0;
    int stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic issue(input string nm, input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input bit expect_rsp);
        exp_t e;
        @(negedge clk);
        stall = 0;
        while (!req_ready && stall < 8) begin
            @(negedge clk);
            stall++;
        end
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        if (expect_rsp) begin
            e.due = cyc + lat; e.rdata = exp_rdata; e.err = exp_err;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        // scramble request fields to prove they were latched at accept
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_size = ~size;
        req_unsigned = ~uns; req_we = ~we;
        if (expect_rsp && lat == 2) begin
            @(negedge clk);
            chk({nm, "_busy"}, 32'(req_ready), 32'd0);
        end
    endtask

    initial begin
        int w0;
        fork
            forever begin
                @(negedge clk);
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("rsp_cycle", 32'(cyc), 32'(e.due));
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
        join_none

        // reset with a live word-store request on the inputs
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 10'h10; req_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // word store then back-to-back load (read-after-write)
        issue("st_w10", 1, 2'b10, 0, 10'h10, 32'hDEAD_BEEF, 32'd0, 0, 1, 1);
        issue("ld_w10", 0, 2'b10, 0, 10'h10, 32'd0, 32'hDEAD_BEEF, 0, 2, 1);
        // word store throughput
        issue("st_w14", 1, 2'b10, 0, 10'h14, 32'h1234_5678, 32'd0, 0, 1, 1);
        issue("st_w18", 1, 2'b10, 0, 10'h18, 32'hCAFE_F00D, 32'd0, 0, 1, 1);
        chk("b2b_stall", 32'(stall), 32'd0);
        issue("ld_w14", 0, 2'b10, 1, 10'h14, 32'd0, 32'h1234_5678, 0, 2, 1);
        issue("ld_w18", 0, 2'b10, 0, 10'h18, 32'd0, 32'hCAFE_F00D, 0, 2, 1);
        issue("st_w20", 1, 2'b10, 0, 10'h20, 32'h1122_3344, 32'd0, 0, 1, 1);

        // errors: no RAM write, response at T+1 with zero data
        repeat (2) @(negedge clk);
        w0 = we_cnt;
        issue("err_ldw12", 0, 2'b10, 0, 10'h12, 32'd0, 32'd0, 1, 1, 1);
        issue("err_stw16", 1, 2'b10, 0, 10'h16, 32'hAAAA_AAAA, 32'd0, 1, 1, 1);
        issue("err_sz11", 1, 2'b11, 0, 10'h10, 32'h5555_5555, 32'd0, 1, 1, 1);
        issue("err_sth23", 1, 2'b01, 0, 10'h23, 32'h0000_BEEF, 32'd0, 1, 1, 1);
`ifndef MEM_SUBWORD_EN
        issue("err_ldb10", 0, 2'b00, 0, 10'h10, 32'd0, 32'd0, 1, 1, 1);
        issue("err_stb20", 1, 2'b00, 0, 10'h20, 32'h0000_00AA, 32'd0, 1, 1, 1);
        issue("err_ldh20", 0, 2'b01, 1, 10'h20, 32'd0, 32'd0, 1, 1, 1);
`endif
        repeat (3) @(negedge clk);
        chk("err_no_write", 32'(we_cnt - w0), 32'd0);
        issue("ld_w10_chk", 0, 2'b10, 0, 10'h10, 32'd0, 32'hDEAD_BEEF, 0, 2, 1);
        issue("ld_w20_chk", 0, 2'b10, 0, 10'h20, 32'd0, 32'h1122_3344, 0, 2, 1);

        // reset during LOAD: no response, ready again right after
        issue("ld_rst", 0, 2'b10, 0, 10'h10, 32'd0, 32'd0, 0, 2, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ld_rst_ready", 32'(req_ready), 32'd1);

`ifdef MEM_SUBWORD_EN
        // load extension
        issue("st_ext", 1, 2'b10, 0, 10'h10, 32'h80FF_7F01, 32'd0, 0, 1, 1);
        issue("ldb_s13", 0, 2'b00, 0, 10'h13, 32'd0, 32'hFFFF_FF80, 0, 2, 1);
        issue("ldb_u13", 0, 2'b00, 1, 10'h13, 32'd0, 32'h0000_0080, 0, 2, 1);
        issue("ldh_s10", 0, 2'b01, 0, 10'h10, 32'd0, 32'h0000_7F01, 0, 2, 1);
        issue("ldh_s12", 0, 2'b01, 0, 10'h12, 32'd0, 32'hFFFF_80FF, 0, 2, 1);
        issue("ldh_u12", 0, 2'b01, 1, 10'h12, 32'd0, 32'h0000_80FF, 0, 2, 1);
        issue("ldb_s12", 0, 2'b00, 0, 10'h12, 32'd0, 32'hFFFF_FFFF, 0, 2, 1);
        issue("ldb_u11", 0, 2'b00, 1, 10'h11, 32'd0, 32'h0000_007F, 0, 2, 1);
        issue("ldb_s10", 0, 2'b00, 0, 10'h10, 32'd0, 32'h0000_0001, 0, 2, 1);
        // read-modify-write stores
        issue("stb_21", 1, 2'b00, 0, 10'h21, 32'h0000_00AA, 32'd0, 0, 2, 1);
        issue("sth_22", 1, 2'b01, 0, 10'h22, 32'h0000_BEEF, 32'd0, 0, 2, 1);
        issue("ld_w20_m", 0, 2'b10, 0, 10'h20, 32'd0, 32'hBEEF_AA44, 0, 2, 1);
        issue("stb_20", 1, 2'b00, 0, 10'h20, 32'hFFFF_FF5A, 32'd0, 0, 2, 1);
        issue("ld_w20_m2", 0, 2'b10, 0, 10'h20, 32'd0, 32'hBEEF_AA5A, 0, 2, 1);
        // reset during MERGE suppresses the write
        issue("st_w30", 1, 2'b10, 0, 10'h30, 32'd0, 32'd0, 0, 1, 1);
        issue("stb_rst", 1, 2'b00, 0, 10'h30, 32'h0000_0055, 32'd0, 0, 2, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrg_rst_ready", 32'(req_ready), 32'd1);
        issue("ld_w30", 0, 2'b10, 0, 10'h30, 32'd0, 32'd0, 0, 2, 1);
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side data-memory access unit for the pipeline CPU's MEM stage. It accepts load/store requests on a valid/ready handshake and drives a single-port word RAM that has a registered read address, which gives one cycle of read latency. Byte and halfword stores are done by read-modify-write. Loads are returned with sign or zero extension.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM word-address width. RAM depth is 2**ADDR_WIDTH words of 32 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  input  ADDR_WIDTH+2  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle completion pulse; no backpressure
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  request was misaligned or illegal; RAM left untouched
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_WIDTH  RAM word address, equal to req_addr[ADDR_WIDTH+1:2]
- ram_din  output  32  RAM write data
- ram_dout  input  32  RAM read data, valid the cycle after the address is presented

## Operation
- The FSM has three states: IDLE, LOAD and MERGE.
- req_ready is 1 only in IDLE with rst low. A request is accepted when req_valid && req_ready.
- **Error check at accept:**
  - req_size = 11 is an error.
  - A halfword with addr[0] = 1 is an error.
  - A word with addr[1:0] ≠ 00 is an error.
  - On error: ram_we = 0, rsp_valid = 1 and rsp_err = 1 next cycle, state stays IDLE.
- **Word store:** in the accept cycle, ram_we = 1 and ram_din = req_wdata. Next cycle rsp_valid = 1. State stays IDLE.
- **Load:** ram_addr is presented in the accept cycle and the FSM moves to LOAD.
  - In LOAD, the selected lane of ram_dout is extended and registered into rsp_rdata.
  - Next cycle rsp_valid = 1 and the FSM returns to IDLE.
- **Sub-word store:** ram_addr is presented in the accept cycle (a read) and the FSM moves to MERGE.
  - In MERGE: ram_we = 1, ram_addr = the latched word address, ram_din = ram_dout with the target lane(s) replaced by req_wdata[7:0] or [15:0].
  - Next cycle rsp_valid = 1 and the FSM returns to IDLE.
- **Lanes (little-endian):** byte k = bits [8k+7:8k], with k = addr[1:0]. Halfword lane = addr[1].
- The address, size, unsigned flag and wdata are latched at accept; later changes to the req_* inputs have no effect.
- ram_we is 0 in every cycle not listed above.

## Timing
- **Reset values:** state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- **Combinational outputs during rst:** req_ready 0 and ram_we 0.
- **Latency from accept cycle T:**
  - Word store and errors: rsp_valid at T+1.
  - Loads and sub-word stores: rsp_valid at T+2.
- **Throughput:** word stores 1/cycle. Loads and sub-word stores 1 per 2 cycles, with req_ready = 0 at T+1.
- **Read-after-write:** a load accepted at T+1 after a store completed its write at T returns the new data. No forwarding is needed because the RAM write lands at the T edge.
- rsp_valid asserts only in the cycle after completion; rsp_rdata and rsp_err hold until the next response.
- **Reset mid-operation:**
  - If rst is high in LOAD or MERGE, the operation is abandoned.
  - The MERGE write is suppressed, no response is issued, and the FSM is in IDLE the next cycle.

## Configuration
- Macro: MEM_SUBWORD_EN.
- **Defined:** byte and halfword accesses behave as above; the MERGE state and lane logic are present.
- **Undefined:** only word accesses are supported. Any req_size ≠ 10 is an error (rsp_err = 1 at T+1, no RAM access). The MERGE state and extension logic are removed, and loads return the raw word.

## Test plan
- **Word store/load:** store 0xDEADBEEF to byte address 0x10, then load word 0x10 → rsp at T+1 for the store, then rsp_rdata = 0xDEADBEEF at T+2 of the load.
- **Byte load extension:** word 0x10 = 0x80FF7F01.
  - Signed byte at 0x13 → 0xFFFFFF80.
  - Unsigned byte at 0x13 → 0x00000080.
  - Signed halfword at 0x10 → 0x00007F01.
- **Sub-word store:** word 0x20 = 0x11223344. Byte store 0xAA to 0x21, then halfword store 0xBEEF to 0x22 → word reads back 0xBEEFAA44. req_ready = 0 in each MERGE cycle.
- **Misalignment:** word load at 0x12, or halfword store at 0x23 → rsp_err = 1 at T+1, rsp_rdata = 0, ram_we never asserted, target word unchanged.
- **Reset during MERGE:** byte store 0x55 to 0x30 (word = 0), with rst high in the MERGE cycle → no rsp_valid, word 0x30 stays 0, req_ready = 1 the cycle after rst falls.
- **Without MEM_SUBWORD_EN:** byte load at 0x10 → rsp_err = 1 at T+1, no RAM access.
